// File: rtl/div_seq_if.sv
// Handshake and data bundle between the execute stage and the sequential divider.
interface div_seq_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic        hilo_we;
  logic [63:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_div, ready, hilo_we, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_div, ready, hilo_we, result
  );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU: one restoring radix-2 step per cycle, result {HI=rem, LO=quo}.
// Stalls the pipeline while busy and raises a one-cycle HI/LO write enable in DONE.
module div_seq (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT              state, nextState;
  logic        [5:0]  count;
  logic        [31:0] remReg, quoReg, divReg;
  logic               negQ, negR;
  logic        [63:0] resultReg;
  logic        [32:0] shifted;
  logic        [31:0] diff;
  logic               geq;
  logic        [31:0] remFix, quoFix;
  logic               accept;
  logic               doneLive;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic isSigned);
    logic signed [31:0] n;
    n = -v;
    return (isSigned && v[31]) ? n : v;
  endfunction

  function automatic logic [31:0] applySign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign accept   = bus.start && !bus.annul;
  assign doneLive = (state == DONE) && !bus.annul;

  // Restoring step: remainder stays below the divisor, so 32 bits hold it after subtraction.
  assign shifted = {remReg, quoReg[31]};
  assign geq     = shifted >= {1'b0, divReg};
  assign diff    = shifted[31:0] - divReg;

  assign remFix = applySign(remReg, negR);
  assign quoFix = applySign(quoReg, negQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = (bus.b == 32'd0) ? DONE : BUSY;
      BUSY: begin
        if (bus.annul)             nextState = IDLE;
        else if (count == 6'd31)   nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      remReg    <= '0;
      quoReg    <= '0;
      divReg    <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      resultReg <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          count <= '0;
          if (bus.b == 32'd0) begin
            // Divide by zero skips the iteration and the sign fix-up.
            remReg <= bus.a;
            quoReg <= 32'hFFFF_FFFF;
            negQ   <= 1'b0;
            negR   <= 1'b0;
          end else begin
            remReg <= '0;
            quoReg <= magnitude(bus.a, bus.signed_div);
            divReg <= magnitude(bus.b, bus.signed_div);
            negQ   <= bus.signed_div && (bus.a[31] ^ bus.b[31]);
            negR   <= bus.signed_div && bus.a[31];
          end
        end
        BUSY: if (!bus.annul) begin
          remReg <= geq ? diff : shifted[31:0];
          quoReg <= {quoReg[30:0], geq};
          count  <= count + 6'd1;
        end
        DONE: if (!bus.annul) resultReg <= {remFix, quoFix};
        default: ;
      endcase
    end
  end

  // Fresh result is presented during DONE; an annul in that cycle keeps the held value.
  assign bus.result    = doneLive ? {remFix, quoFix} : resultReg;
  assign bus.ready     = doneLive;
  assign bus.hilo_we   = doneLive;
  assign bus.stall_div = !rst && (((state == IDLE) && accept) || ((state == BUSY) && !bus.annul));
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall/ready timing, signed fix-up, annul and reset cases.
module tb_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] prior;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic startDiv(input logic sgn, input logic [31:0] av, input logic [31:0] bv, input string tag);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.a          = av;
    bus.b          = bv;
    bus.annul      = 1'b0;
    @(negedge clk);
    chk({tag, "_stallT"}, 64'(bus.stall_div), 64'd1);
    chk({tag, "_readyT"}, 64'({bus.ready, bus.hilo_we}), 64'd0);
  endtask

  task automatic waitResult(input int expLat, input logic [63:0] expRes, input string tag);
    int lat;
    int bad;
    lat = -1;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.ready) begin
        lat = k;
        break;
      end
      if (bus.stall_div !== 1'b1 || bus.hilo_we !== 1'b0) bad++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(expLat));
    chk({tag, "_busyStall"}, 64'(bad), 64'd0);
    chk({tag, "_result"}, bus.result, expRes);
    chk({tag, "_hiloWe"}, 64'(bus.hilo_we), 64'd1);
    chk({tag, "_stallDone"}, 64'(bus.stall_div), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_readyAfter"}, 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk({tag, "_hold"}, bus.result, expRes);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd1;
    bus.b          = 32'd1;
    bus.annul      = 1'b0;

    // Reset: outputs quiet even with a request pending
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(bus.stall_div), 64'd0);
    chk("rst_ready", 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    startDiv(1'b0, 32'd100, 32'd7, "divu100_7");
    waitResult(33, {32'd2, 32'd14}, "divu100_7");

    startDiv(1'b1, 32'hFFFF_FFF9, 32'd2, "divm7_2");
    waitResult(33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "divm7_2");

    startDiv(1'b1, 32'h0000_1234, 32'd0, "divz");
    waitResult(1, {32'h0000_1234, 32'hFFFF_FFFF}, "divz");

    startDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "divOvf");
    waitResult(33, {32'h0000_0000, 32'h8000_0000}, "divOvf");

    startDiv(1'b1, 32'd7, 32'hFFFF_FFFE, "div7_m2");
    waitResult(33, {32'd1, 32'hFFFF_FFFD}, "div7_m2");

    startDiv(1'b0, 32'hFFFF_FFFF, 32'h10, "divuMax");
    waitResult(33, {32'h0000_000F, 32'h0FFF_FFFF}, "divuMax");
    prior = {32'h0000_000F, 32'h0FFF_FFFF};

    // Annul mid-BUSY at T+10, then a zero-divisor request at T+11 proves IDLE
    startDiv(1'b0, 32'd50, 32'd5, "annBusy");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("annBusy_stall", 64'(bus.stall_div), 64'd0);
    chk("annBusy_we", 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk("annBusy_res", bus.result, prior);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    bus.start = 1'b1;
    bus.a     = 32'h55;
    bus.b     = 32'd0;
    @(negedge clk);
    chk("annBusy_idleStall", 64'(bus.stall_div), 64'd1);
    chk("annBusy_idleWe", 64'(bus.hilo_we), 64'd0);
    chk("annBusy_idleRes", bus.result, prior);
    waitResult(1, {32'h55, 32'hFFFF_FFFF}, "annIdle");
    prior = {32'h55, 32'hFFFF_FFFF};

    // Annul landing on the DONE cycle
    startDiv(1'b0, 32'd9, 32'd3, "annDone");
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annDone_we", 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk("annDone_res", bus.result, prior);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("annDone_after", 64'({bus.ready, bus.hilo_we, bus.stall_div}), 64'd0);
    chk("annDone_hold", bus.result, prior);

    // start together with annul in IDLE is dropped
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.a     = 32'd8;
    bus.b     = 32'd0;
    @(negedge clk);
    chk("annStart_stall", 64'(bus.stall_div), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("annStart_ready", 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk("annStart_res", bus.result, prior);

    // Reset at T+20, request held through release
    startDiv(1'b0, 32'd1000, 32'd10, "rstMid");
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstMid_stall", 64'(bus.stall_div), 64'd0);
    chk("rstMid_we", 64'({bus.ready, bus.hilo_we}), 64'd0);
    chk("rstMid_res", bus.result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstMid_restart", 64'(bus.stall_div), 64'd1);
    waitResult(33, {32'd0, 32'd100}, "rstMid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
